hazard_sequencer: RTL
=====================

HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset as in the rest of the PPU.
REQ-002 clk  in  1  pipeline clock; all state updates on the rising edge.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 id_rs, id_rt  in  5 each  source register fields of the instruction in IF/ID.
REQ-005 id_use_rs, id_use_rt  in  1 each  ID instruction reads rs / rt.
REQ-006 ex_rd, mem_rd, wb_rd  in  5 each  destination register in the EX, MEM and WB stages.
REQ-007 ex_rf_enable, mem_rf_enable, wb_rf_enable  in  1 each  stage will write the register file.
REQ-008 ex_load_instr  in  1  EX instruction is a load.
REQ-009 ext_hold  in  1  memory busy; the whole pipeline freezes.
REQ-010 pc_ld, npc_ld, ifid_ld  out  1 each  load enables for PC, nPC and the IF/ID register.
REQ-011 ctrl_sel  out  1  S select of the control-signal mux: 1 = inject the all-zero NOP word, 0 = pass the control unit output.
REQ-012 pipe_en  out  1  advance enable for ID/EX, EX/MEM and MEM/WB.
REQ-013 fwd_a, fwd_b  out  2 each  operand forwarding select: 00 = RF, 01 = EX/MEM, 10 = MEM/WB, 11 = WB.
REQ-014 stall_count  out  16  cycles in which pc_ld = 0.
REQ-015 state  out  2  current FSM state, for debug.

Function
REQ-016 States SHALL be RUN = 0, LU_STALL = 1 and HOLD = 2; encoding 3 is illegal and SHALL return to RUN on the next edge.
REQ-017 The load-use hazard lu SHALL be: ex_load_instr & ex_rf_enable & ex_rd != 0 & ((id_use_rs & id_rs == ex_rd) | (id_use_rt & id_rt == ex_rd)).
REQ-018 Outputs SHALL be combinational from the current inputs and state, with priority reset > ext_hold > lu > normal.
REQ-019 ext_hold = 1: pc_ld = npc_ld = ifid_ld = pipe_en = 0, ctrl_sel = 0, and next state HOLD.
REQ-020 lu = 1 with ext_hold = 0: pc_ld = npc_ld = ifid_ld = 0, ctrl_sel = 1, pipe_en = 1 (bubble into ID/EX), and next state LU_STALL.
REQ-021 Otherwise: all loads = 1, ctrl_sel = 0, pipe_en = 1, and next state RUN.
REQ-022 LU_STALL SHALL last exactly one cycle when no new hazard occurs; it SHALL re-enter LU_STALL if lu is still true (back-to-back loads).
REQ-023 On HOLD exit, the pipeline SHALL resume with no bubble; if lu is true on the exit cycle, the stall SHALL be taken then.
REQ-024 ext_hold arriving during LU_STALL SHALL freeze the pipeline; the pending bubble is already in ID/EX and SHALL NOT be duplicated.
REQ-025 Forwarding per operand SHALL use the priority EX/MEM (01) > MEM/WB (10) > WB (11) > RF (00).
REQ-026 A stage SHALL match only when its rf_enable = 1, its rd equals the source field, and rd != 0.
REQ-027 An EX match with ex_load_instr = 1 SHALL be excluded from forwarding, because the lu stall covers that case.
REQ-028 fwd_a and fwd_b SHALL be 00 when the operand is unused.
REQ-029 stall_count SHALL increment by 1 on every edge where pc_ld = 0 and reset = 0, and SHALL saturate at 16'hFFFF.

Reset
REQ-030 On a reset edge, state SHALL become RUN and stall_count SHALL become 0.
REQ-031 While reset = 1, outputs SHALL be forced: pc_ld = npc_ld = ifid_ld = 0, pipe_en = 0, ctrl_sel = 1, fwd_a = fwd_b = 00.
REQ-032 Reset asserted mid-stall or mid-hold SHALL abandon that stall or hold with no residual bubble after release.

Structure
REQ-033 A shared package ppu_pkg SHALL hold the state encodings (RUN, LU_STALL, HOLD), the FWD_RF/FWD_EX/FWD_MEM/FWD_WB constants, and REG_W = 5.
REQ-034 A sub-module fwd_select SHALL compute the priority select for one operand and SHALL be instantiated twice (rs → fwd_a, rt → fwd_b).
REQ-035 The FSM and stall_count SHALL be the only state in the block; the total implementation is 120–250 lines.

Verification
REQ-036 Load-use: ex_load_instr = 1, ex_rd = 8, id_rs = 8, id_use_rs = 1 → one cycle with pc_ld = 0 and ctrl_sel = 1, state LU_STALL, then RUN with fwd_a = 10; stall_count = 1.
REQ-037 Forwarding priority: ex_rd = mem_rd = wb_rd = 5, all rf_enable = 1, id_rt = 5, id_use_rt = 1, no load → fwd_b = 01; with ex_rf_enable = 0 → fwd_b = 10.
REQ-038 Register zero: ex_rd = 0, id_rs = 0, load in EX → no stall and fwd_a = 00.
REQ-039 Hold during stall: lu cycle followed by ext_hold for 3 cycles → exactly one bubble, state HOLD for 3 cycles, then RUN; stall_count = 4.
REQ-040 Reset mid-hold: reset pulsed in HOLD → state RUN, stall_count 0, forced outputs during reset, normal loads = 1 on the first cycle after release.
REQ-041 Saturation: preload stall_count near 16'hFFFF and hold ext_hold → the count stops at 16'hFFFF and does not wrap to 0.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared PPU definitions: sequencer state encodings, forwarding select codes, field widths.
package ppu_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned FWD_W = 2;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    HOLD     = 2'd2
  } seq_state_e;

  localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
  localparam logic [FWD_W-1:0] FWD_EX  = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

endpackage

// File: rtl/fwd_select.sv
// Priority operand-forwarding select for one source register field.
module fwd_select
  import ppu_pkg::*;
(
  input  logic [REG_W-1:0] src_i,
  input  logic             use_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             ex_rf_enable_i,
  input  logic             ex_load_i,
  input  logic [REG_W-1:0] mem_rd_i,
  input  logic             mem_rf_enable_i,
  input  logic [REG_W-1:0] wb_rd_i,
  input  logic             wb_rf_enable_i,
  output logic [FWD_W-1:0] sel_o
);

  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  // A load in EX is never forwarded; the load-use stall resolves it instead.
  assign ex_hit  = ex_rf_enable_i & ~ex_load_i & (ex_rd_i != '0) & (ex_rd_i == src_i);
  assign mem_hit = mem_rf_enable_i & (mem_rd_i != '0) & (mem_rd_i == src_i);
  assign wb_hit  = wb_rf_enable_i & (wb_rd_i != '0) & (wb_rd_i == src_i);

  always_comb begin
    sel_o = FWD_RF;
    if (use_i) begin
      if (ex_hit) begin
        sel_o = FWD_EX;
      end else if (mem_hit) begin
        sel_o = FWD_MEM;
      end else if (wb_hit) begin
        sel_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: load-use stall, external hold freeze, operand forwarding
// selects and a saturating count of PC-stalled cycles.
module hazard_sequencer
  import ppu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] mem_rd,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             ex_rf_enable,
  input  logic             mem_rf_enable,
  input  logic             wb_rf_enable,
  input  logic             ex_load_instr,
  input  logic             ext_hold,
  output logic             pc_ld,
  output logic             npc_ld,
  output logic             ifid_ld,
  output logic             ctrl_sel,
  output logic             pipe_en,
  output logic [FWD_W-1:0] fwd_a,
  output logic [FWD_W-1:0] fwd_b,
  output logic [CNT_W-1:0] stall_count,
  output logic [1:0]       state
);

  seq_state_e       state_q;
  seq_state_e       state_d;
  logic [CNT_W-1:0] stall_count_q;
  logic [CNT_W-1:0] stall_count_d;
  logic             lu;
  logic [FWD_W-1:0] fwd_a_raw;
  logic [FWD_W-1:0] fwd_b_raw;

  assign lu = ex_load_instr & ex_rf_enable & (ex_rd != '0) &
              ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));

  fwd_select u_fwd_a (
    .src_i           (id_rs),
    .use_i           (id_use_rs),
    .ex_rd_i         (ex_rd),
    .ex_rf_enable_i  (ex_rf_enable),
    .ex_load_i       (ex_load_instr),
    .mem_rd_i        (mem_rd),
    .mem_rf_enable_i (mem_rf_enable),
    .wb_rd_i         (wb_rd),
    .wb_rf_enable_i  (wb_rf_enable),
    .sel_o           (fwd_a_raw)
  );

  fwd_select u_fwd_b (
    .src_i           (id_rt),
    .use_i           (id_use_rt),
    .ex_rd_i         (ex_rd),
    .ex_rf_enable_i  (ex_rf_enable),
    .ex_load_i       (ex_load_instr),
    .mem_rd_i        (mem_rd),
    .mem_rf_enable_i (mem_rf_enable),
    .wb_rd_i         (wb_rd),
    .wb_rf_enable_i  (wb_rf_enable),
    .sel_o           (fwd_b_raw)
  );

  // State register and saturating stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      stall_count_q <= stall_count_d;
    end
  end

  // Next state and load/advance controls; the decision depends only on the current
  // inputs, so an illegal state encoding also falls back to RUN on the next edge.
  always_comb begin
    state_d  = RUN;
    pc_ld    = 1'b1;
    npc_ld   = 1'b1;
    ifid_ld  = 1'b1;
    ctrl_sel = 1'b0;
    pipe_en  = 1'b1;
    fwd_a    = fwd_a_raw;
    fwd_b    = fwd_b_raw;
    if (reset) begin
      pc_ld    = 1'b0;
      npc_ld   = 1'b0;
      ifid_ld  = 1'b0;
      ctrl_sel = 1'b1;
      pipe_en  = 1'b0;
      fwd_a    = FWD_RF;
      fwd_b    = FWD_RF;
    end else if (ext_hold) begin
      state_d  = HOLD;
      pc_ld    = 1'b0;
      npc_ld   = 1'b0;
      ifid_ld  = 1'b0;
      pipe_en  = 1'b0;
    end else if (lu) begin
      state_d  = LU_STALL;
      pc_ld    = 1'b0;
      npc_ld   = 1'b0;
      ifid_ld  = 1'b0;
      ctrl_sel = 1'b1;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (!pc_ld && (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  assign stall_count = stall_count_q;
  assign state       = 2'(state_q);

endmodule
